match_controller: RTL and testbench
===================================

// Module: match_controller
// PURPOSE
//  Sequences one Pong match while the main FSM has the game enabled: serve countdown, rally, point scoring, win detection.
//  Sits between the main FSM (enable) and the ball/paddle datapath (goal inputs, ball control outputs).
//  Owns both score registers; drives game_over and winner for the main FSM.
// PARAMETERS
//  SCORE_WIDTH  4   width of each score register
//  WIN_SCORE    7   points needed to win; 1 <= WIN_SCORE <= 2**SCORE_WIDTH-1
//  SERVE_DELAY  60  enabled frame_ticks spent in SERVE before play; >= 1
//  CNT_WIDTH    8   width of the serve counter; must hold SERVE_DELAY
// PORTS
//  clock        in   1            system clock, all logic on posedge
//  reset        in   1            synchronous, active-high
//  enable       in   1            game enabled by main FSM; 0 = freeze everything
//  frame_tick   in   1            one-cycle pulse per video frame
//  goal_left    in   1            pulse: ball left the left edge (right player scores)
//  goal_right   in   1            pulse: ball left the right edge (left player scores)
//  score_left   out  SCORE_WIDTH  left player score
//  score_right  out  SCORE_WIDTH  right player score
//  ball_run     out  1            ball may move
//  ball_reset   out  1            one-cycle pulse: re-centre ball
//  serve_dir    out  1            0 = serve toward left, 1 = toward right
//  game_over    out  1            match finished
//  winner       out  1            0 = left won, 1 = right won; valid while game_over=1
// BEHAVIOUR
//  States: SERVE, PLAY, POINT, OVER. Unknown encoding -> SERVE with reset values.
//  Reset: state=SERVE, counter=SERVE_DELAY, scores=0, ball_reset=0, serve_dir=0, game_over=0, winner=0.
//  All outputs are registered except ball_run, which is decoded as (state==PLAY) & enable.
//  enable=0: state, counter, scores and all registered outputs hold; frame_tick and goals are ignored.
//  SERVE
//   - Each enabled frame_tick: if counter==1 -> PLAY, else counter-1.
//   - PLAY is therefore entered exactly SERVE_DELAY ticks after entry.
//  PLAY
//   - Exactly one goal, enabled:
//     - goal_left: score_right+1, serve_dir<=0.
//     - goal_right: score_left+1, serve_dir<=1.
//     - Then -> POINT; the score is visible the next cycle.
//   - goal_left and goal_right both high in the same cycle: ignored; stay in PLAY, no score change.
//  POINT (exactly one enabled cycle)
//   - Updated score == WIN_SCORE: -> OVER, game_over<=1, winner<=scorer.
//   - Otherwise: -> SERVE, counter<=SERVE_DELAY, ball_reset<=1.
//   - ball_reset is high only during the first cycle of SERVE.
//  OVER
//   - Absorbing; holds game_over, winner and the scores until reset.
//   - Goals and ticks are ignored.
//  Latency: goal cycle N -> score at N+1 -> ball_reset or game_over at N+2 (enable held high).
//  Scores never exceed WIN_SCORE and never wrap.
//  Reset mid-operation, any state: next cycle equals the reset values.
// TESTING
//  1 SERVE_DELAY=3, enable=1: 3 frame_ticks -> ball_run=1 the cycle after the 3rd tick; not after 2 ticks.
//  2 PLAY, goal_left pulse -> score_right 0->1 next cycle; ball_reset=1 for 1 cycle at +2; serve_dir=0; ball_run=0.
//  3 Score 6-5 (right leads), goal_left -> score_right=7, game_over=1, winner=1 at +2; later goals -> no change.
//  4 enable=0 in SERVE with 5 ticks, then in PLAY with goal_right -> counter and scores unchanged, ball_run=0.
//  5 goal_left & goal_right in the same PLAY cycle -> scores unchanged, state stays PLAY, ball_reset=0.
//  6 reset=1 in PLAY at score 3-2 -> next cycle: scores 0-0, SERVE, counter=SERVE_DELAY, all outputs 0.

Source files
------------

// File: rtl/match_controller.sv
// Pong match sequencer: serve countdown, rally, point scoring and win detection.
// Everything freezes while enable is low; ball_run is the only decoded output.
module match_controller #(
    parameter int SCORE_WIDTH = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   frame_tick,
    input  logic                   goal_left,
    input  logic                   goal_right,
    output logic [SCORE_WIDTH-1:0] score_left,
    output logic [SCORE_WIDTH-1:0] score_right,
    output logic                   ball_run,
    output logic                   ball_reset,
    output logic                   serve_dir,
    output logic                   game_over,
    output logic                   winner
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [SCORE_WIDTH-1:0] LP_WIN   = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [CNT_WIDTH-1:0]   LP_DELAY = CNT_WIDTH'(SERVE_DELAY);
    localparam logic [CNT_WIDTH-1:0]   LP_ONE   = CNT_WIDTH'(1);

    state_t                 r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [SCORE_WIDTH-1:0] r_score_l, w_score_l_nxt;
    logic [SCORE_WIDTH-1:0] r_score_r, w_score_r_nxt;
    logic                   r_ball_reset, w_ball_reset_nxt;
    logic                   r_serve_dir, w_serve_dir_nxt;
    logic                   r_game_over, w_game_over_nxt;
    logic                   r_winner, w_winner_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_SERVE;
            r_cnt        <= LP_DELAY;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_ball_reset <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_score_l    <= w_score_l_nxt;
            r_score_r    <= w_score_r_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_serve_dir  <= w_serve_dir_nxt;
            r_game_over  <= w_game_over_nxt;
            r_winner     <= w_winner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_score_l_nxt    = r_score_l;
        w_score_r_nxt    = r_score_r;
        w_ball_reset_nxt = r_ball_reset;
        w_serve_dir_nxt  = r_serve_dir;
        w_game_over_nxt  = r_game_over;
        w_winner_nxt     = r_winner;

        if (enable) begin
            // ball_reset is only ever raised on the POINT->SERVE edge
            w_ball_reset_nxt = 1'b0;
            case (r_state)
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (r_cnt == LP_ONE) w_state_nxt = ST_PLAY;
                        else                 w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                ST_PLAY: begin
                    // simultaneous goals are treated as noise and dropped
                    if (goal_left && !goal_right) begin
                        if (r_score_r < LP_WIN) w_score_r_nxt = r_score_r + 1'b1;
                        w_serve_dir_nxt = 1'b0;
                        w_state_nxt     = ST_POINT;
                    end else if (goal_right && !goal_left) begin
                        if (r_score_l < LP_WIN) w_score_l_nxt = r_score_l + 1'b1;
                        w_serve_dir_nxt = 1'b1;
                        w_state_nxt     = ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (r_score_r == LP_WIN || r_score_l == LP_WIN) begin
                        w_state_nxt     = ST_OVER;
                        w_game_over_nxt = 1'b1;
                        w_winner_nxt    = (r_score_r == LP_WIN);
                    end else begin
                        w_state_nxt      = ST_SERVE;
                        w_cnt_nxt        = LP_DELAY;
                        w_ball_reset_nxt = 1'b1;
                    end
                end
                ST_OVER: begin
                end
                default: begin
                    w_state_nxt      = ST_SERVE;
                    w_cnt_nxt        = LP_DELAY;
                    w_score_l_nxt    = '0;
                    w_score_r_nxt    = '0;
                    w_ball_reset_nxt = 1'b0;
                    w_serve_dir_nxt  = 1'b0;
                    w_game_over_nxt  = 1'b0;
                    w_winner_nxt     = 1'b0;
                end
            endcase
        end
    end

    assign score_left  = r_score_l;
    assign score_right = r_score_r;
    assign ball_run    = (r_state == ST_PLAY) && enable;
    assign ball_reset  = r_ball_reset;
    assign serve_dir   = r_serve_dir;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios plus random traffic,
// every cycle compared against a behavioural model of the match rules.
module tb_match_controller;

    localparam int SW  = 4;
    localparam int WIN = 7;
    localparam int DLY = 3;

    logic          clock = 1'b0;
    logic          reset, enable, frame_tick, goal_left, goal_right;
    logic [SW-1:0] score_left, score_right;
    logic          ball_run, ball_reset, serve_dir, game_over, winner;

    int n_chk = 0;
    int n_err = 0;

    // model: phase 0 = waiting to serve, 1 = rally, 2 = point scored, 3 = finished
    int m_phase, m_ticks_left, m_sl, m_sr, m_last_scorer;
    bit m_bres, m_dir, m_over, m_win;

    match_controller #(
        .SCORE_WIDTH(SW), .WIN_SCORE(WIN), .SERVE_DELAY(DLY), .CNT_WIDTH(8)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .goal_left(goal_left), .goal_right(goal_right),
        .score_left(score_left), .score_right(score_right), .ball_run(ball_run),
        .ball_reset(ball_reset), .serve_dir(serve_dir), .game_over(game_over),
        .winner(winner)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_phase = 0; m_ticks_left = DLY; m_sl = 0; m_sr = 0; m_last_scorer = 0;
        m_bres = 0; m_dir = 0; m_over = 0; m_win = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_clear();
        end else if (enable) begin
            m_bres = 0;
            case (m_phase)
                0: if (frame_tick) begin
                       m_ticks_left--;
                       if (m_ticks_left == 0) m_phase = 1;
                   end
                1: if (goal_left != goal_right) begin
                       m_last_scorer = goal_left ? 1 : 0;
                       if (goal_left) m_sr++; else m_sl++;
                       m_dir   = goal_left ? 0 : 1;
                       m_phase = 2;
                   end
                2: begin
                       if ((m_last_scorer ? m_sr : m_sl) >= WIN) begin
                           m_phase = 3; m_over = 1; m_win = m_last_scorer[0];
                       end else begin
                           m_phase = 0; m_ticks_left = DLY; m_bres = 1;
                       end
                   end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("score_left",  score_left,  m_sl);
        chk("score_right", score_right, m_sr);
        chk("ball_run",    ball_run,    int'(m_phase == 1 && enable));
        chk("ball_reset",  ball_reset,  m_bres);
        chk("serve_dir",   serve_dir,   m_dir);
        chk("game_over",   game_over,   m_over);
        chk("winner",      winner,      m_win);
    endtask

    task automatic cyc(input bit rst, input bit en, input bit tk, input bit gl, input bit gr);
        @(negedge clock);
        reset = rst; enable = en; frame_tick = tk; goal_left = gl; goal_right = gr;
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic reach_play();
        int n;
        n = 0;
        while (!ball_run && n < 200) begin
            cyc(0, 1, 1, 0, 0);
            n++;
        end
        if (!ball_run) chk("reach_play_timeout", 0, 1);
    endtask

    task automatic score_point(input bit gl);
        reach_play();
        cyc(0, 1, 0, gl, !gl);
        cyc(0, 1, 0, 0, 0);
    endtask

    initial begin
        reset = 1; enable = 0; frame_tick = 0; goal_left = 0; goal_right = 0;
        model_clear();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("rst_scores", {score_left, score_right}, 0);
        chk("rst_flags", {ball_run, ball_reset, serve_dir, game_over, winner}, 0);

        // serve countdown: not running after 2 ticks, running after the 3rd
        cyc(0, 1, 1, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 0, 0);
        chk("serve_2ticks", ball_run, 0);
        cyc(0, 1, 1, 0, 0);
        chk("serve_3ticks", ball_run, 1);

        // goal_left during rally
        cyc(0, 1, 0, 1, 0);
        chk("goal_score_r", score_right, 1);
        chk("goal_run_off", ball_run, 0);
        cyc(0, 1, 0, 0, 0);
        chk("goal_ball_reset", ball_reset, 1);
        chk("goal_dir", serve_dir, 0);
        cyc(0, 1, 0, 0, 0);
        chk("ball_reset_pulse", ball_reset, 0);

        // freeze in SERVE: 5 ticks ignored, then still needs 3 real ticks
        repeat (5) cyc(0, 0, 1, 0, 0);
        chk("frz_serve_run", ball_run, 0);
        cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0);
        chk("frz_not_yet", ball_run, 0);
        cyc(0, 1, 1, 0, 0);
        chk("frz_play", ball_run, 1);
        cyc(0, 0, 0, 0, 1);
        chk("frz_goal_ign", {score_left, score_right}, {4'd0, 4'd1});
        chk("frz_run_off", ball_run, 0);

        // both goals together are dropped
        cyc(0, 1, 0, 1, 1);
        chk("dual_scores", {score_left, score_right}, {4'd0, 4'd1});
        chk("dual_stay_play", ball_run, 1);
        cyc(0, 1, 0, 0, 0);
        chk("dual_no_reset", ball_reset, 0);

        // drive to 5-6 then the right player wins
        repeat (5) score_point(0);
        repeat (5) score_point(1);
        chk("pre_win", {score_left, score_right}, {4'd5, 4'd6});
        reach_play();
        cyc(0, 1, 0, 1, 0);
        chk("win_score", score_right, 7);
        cyc(0, 1, 0, 0, 0);
        chk("win_over", game_over, 1);
        chk("win_who", winner, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, i[0], !i[0]);
        chk("over_hold", {score_left, score_right, game_over}, {4'd5, 4'd7, 1'b1});

        // reset mid-rally at 3-2
        cyc(1, 1, 0, 0, 0);
        repeat (3) score_point(1);
        repeat (2) score_point(0);
        reach_play();
        cyc(1, 1, 0, 0, 0);
        chk("mid_rst_scores", {score_left, score_right}, 0);
        chk("mid_rst_flags", {ball_run, ball_reset, serve_dir, game_over, winner}, 0);
        cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0);
        chk("mid_rst_cnt", ball_run, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 600 == 0) || (m_over && $urandom % 15 == 0),
                ($urandom % 6) != 0, ($urandom % 3) == 0,
                ($urandom % 8) == 0, ($urandom % 8) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
